elbeth_mem_arbiter: RTL and testbench

ELBETH_MEM_ARBITER -- requirements
Module: elbeth_mem_arbiter

---
 rtl/elbeth_mem_arbiter_pkg.sv | 16 +
 rtl/elbeth_mem_arbiter_rr_arbiter2.sv | 32 +++
 rtl/elbeth_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_elbeth_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elbeth_mem_arbiter_pkg.sv
// Shared definitions for the elbeth memory arbiter: FSM encodings and
// default sizing parameters.
package elbeth_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_AW      = 8;
   localparam int DEF_TIMEOUT = 15;
   localparam int CNT_W       = 8;

endpackage

// File: rtl/elbeth_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin selector: a standing tie goes to the master that was
// not granted last; the pointer resets so that master 0 wins the first tie.
module elbeth_rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       gnt_valid_o,
   output logic       gnt_idx_o
);

   logic last_q;

   always_comb begin
      gnt_valid_o = |req_i;
      gnt_idx_o   = 1'b0;
      if (req_i == 2'b11) begin
         gnt_idx_o = ~last_q;
      end else begin
         gnt_idx_o = req_i[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (take_i && gnt_valid_o) begin
         last_q <= gnt_idx_o;
      end
   end

endmodule

// File: rtl/elbeth_mem_arbiter.sv
// Two-master arbiter onto a single-cycle-issue memory port with a
// ready-timeout; one outstanding transaction at a time.
module elbeth_mem_arbiter
   import elbeth_mem_arbiter_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [31:0]   m0_wdata,
   input  logic [3:0]    m0_we,
   output logic [31:0]   m0_rdata,
   output logic          m0_ack,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [31:0]   m1_wdata,
   input  logic [3:0]    m1_we,
   output logic [31:0]   m1_rdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic          mem_enable,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_data_in,
   output logic [3:0]    mem_rw,
   input  logic [31:0]   mem_data_out,
   input  logic          mem_ready
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_e            state_q, state_d;
   logic [AW-1:0]     addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        we_q;
   logic              gnt_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       rdata0_q, rdata1_q;
   logic              take;
   logic              gnt_valid;
   logic              gnt_idx;
   logic              timed_out;

   elbeth_rr_arbiter2 u_rr (
      .clk         (clk),
      .rst         (rst),
      .req_i       ({m1_req, m0_req}),
      .take_i      (take),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   assign timed_out = (cnt_q == TIMEOUT_C);

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid) begin
               take    = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (mem_ready || timed_out) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath: request latch, wait counter and per-master read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= '0;
         gnt_q    <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (gnt_valid) begin
                  gnt_q   <= gnt_idx;
                  addr_q  <= gnt_idx ? m1_addr  : m0_addr;
                  wdata_q <= gnt_idx ? m1_wdata : m0_wdata;
                  we_q    <= gnt_idx ? m1_we    : m0_we;
               end
            end
            ST_ISSUE: cnt_q <= CNT_W'(1);
            ST_WAIT: begin
               if (mem_ready) begin
                  err_q <= 1'b0;
                  if (gnt_q) rdata1_q <= mem_data_out;
                  else       rdata0_q <= mem_data_out;
               end else if (timed_out) begin
                  err_q <= 1'b1;
                  if (gnt_q) rdata1_q <= '0;
                  else       rdata0_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_enable  = (state_q == ST_ISSUE);
   assign mem_rw      = mem_enable ? we_q : 4'b0000;
   assign mem_addr    = addr_q;
   assign mem_data_in = wdata_q;

   assign m0_ack   = (state_q == ST_DONE) && !gnt_q;
   assign m1_ack   = (state_q == ST_DONE) &&  gnt_q;
   assign m0_err   = m0_ack && err_q;
   assign m1_err   = m1_ack && err_q;
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter: a transaction table against a small
// byte-enable memory model, plus arbitration, timeout and reset sequences.
module tb_elbeth_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req;
   logic [7:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_we, m1_we;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        mem_enable;
   logic [7:0]  mem_addr;
   logic [31:0] mem_data_in;
   logic [3:0]  mem_rw;
   logic [31:0] mem_data_out;
   logic        mem_ready;

   logic        stall;
   logic        mem_clear;
   logic [31:0] mem [256];
   logic [31:0] mem_rd_q;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;

   elbeth_mem_arbiter #(.AW(8), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_rw(mem_rw), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
   );

   // Memory: returns the pre-write word one cycle after enable; stall holds ready low.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
         mem[8'h10] <= 32'hDEADBEEF;
         mem_ready  <= 1'b0;
         mem_rd_q   <= 32'h0;
      end else begin
         mem_ready <= mem_enable & ~stall;
         if (mem_enable) begin
            mem_rd_q <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
               if (mem_rw[b]) mem[mem_addr][8*b +: 8] <= mem_data_in[8*b +: 8];
         end
      end
   end
   assign mem_data_out = mem_ready ? mem_rd_q : 32'h0;

   typedef struct {
      int          m;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  we;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int m, input logic r, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] we);
      if (m == 0) begin
         m0_req = r; m0_addr = a; m0_wdata = wd; m0_we = we;
      end else begin
         m1_req = r; m1_addr = a; m1_wdata = wd; m1_we = we;
      end
   endtask

   // Call at a negedge with the bus idle; returns at a negedge back in IDLE.
   task automatic run_txn(input int m, input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] we, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
      int          n = 0;
      int          en_cnt = 0;
      logic        got = 1'b0;
      logic        other_ack = 1'b0;
      logic        bad_rw = 1'b0;
      logic        err_seen = 1'b0;
      logic [3:0]  rw_seen = 4'h0;
      logic [7:0]  addr_seen = 8'h0;
      logic [31:0] data_seen = 32'h0;
      drive(m, 1'b1, a, wd, we);
      while (!got && n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (n == 1) drive(m, 1'b1, ~a, ~wd, ~we);
         if (mem_enable) begin
            en_cnt++;
            rw_seen   = mem_rw;
            addr_seen = mem_addr;
            data_seen = mem_data_in;
         end else if (mem_rw != 4'h0) begin
            bad_rw = 1'b1;
         end
         if ((m == 0) ? m1_ack : m0_ack) other_ack = 1'b1;
         if ((m == 0) ? m0_ack : m1_ack) begin
            got      = 1'b1;
            err_seen = (m == 0) ? m0_err : m1_err;
         end
      end
      check("ack_seen", 32'(got), 32'd1);
      check("latency", 32'(n), 32'(exp_lat));
      check("err", 32'(err_seen), 32'(exp_err));
      check("rdata", (m == 0) ? m0_rdata : m1_rdata, exp_rd);
      check("other_rdata_hold", (m == 0) ? m1_rdata : m0_rdata, last_rd[1-m]);
      check("other_ack", 32'(other_ack), 32'd0);
      check("issue_cycles", 32'(en_cnt), 32'd1);
      check("mem_rw", 32'(rw_seen), 32'(we));
      check("mem_addr", 32'(addr_seen), 32'(a));
      if (we != 4'h0) check("mem_data_in", data_seen, wd);
      check("rw_idle_zero", 32'(bad_rw), 32'd0);
      last_rd[m] = exp_rd;
      drive(m, 1'b0, 8'h0, 32'h0, 4'h0);
      @(posedge clk);
      @(negedge clk);
      check("ack_pulse", {30'h0, m1_ack, m0_ack}, 32'h0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
   endtask

   initial begin
      int n;
      int acks;
      rst = 1'b1; mem_clear = 1'b1; stall = 1'b0;
      drive(0, 1'b0, 8'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 8'h0, 32'h0, 4'h0);
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;

      vecs[0] = '{0, 8'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
      vecs[1] = '{1, 8'h20, 32'hA5A5A5A5, 4'b0011, 32'h00000000};
      vecs[2] = '{0, 8'h20, 32'h0,        4'b0000, 32'h0000A5A5};
      vecs[3] = '{1, 8'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
      vecs[4] = '{0, 8'h10, 32'h12345678, 4'b1100, 32'hDEADBEEF};
      vecs[5] = '{1, 8'h10, 32'h0,        4'b0000, 32'h1234BEEF};
      vecs[6] = '{0, 8'h30, 32'hFFFFFFFF, 4'b1111, 32'h00000000};
      vecs[7] = '{0, 8'h30, 32'h0,        4'b0000, 32'hFFFFFFFF};
      vecs[8] = '{1, 8'hFF, 32'hCAFEF00D, 4'b0100, 32'h00000000};
      vecs[9] = '{1, 8'hFF, 32'h0,        4'b0000, 32'h00FE0000};

      #1;
      check("rst_m0_ack", 32'(m0_ack), 32'd0);
      check("rst_mem_enable", 32'(mem_enable), 32'd0);
      check("rst_mem_rw", 32'(mem_rw), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      check("rst_m1_rdata", m1_rdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; mem_clear = 1'b0;
      @(negedge clk);

      foreach (vecs[i])
         run_txn(vecs[i].m, vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].exp_rd, 1'b0, 3);

      // Both masters hold requests from the same cycle after reset.
      pulse_reset();
      drive(0, 1'b1, 8'h10, 32'h0, 4'h0);
      drive(1, 1'b1, 8'h20, 32'h0, 4'h0);
      acks = 0;
      for (n = 1; n <= 16; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (m0_ack || m1_ack) acks++;
         if (n == 3 || n == 11) begin
            check("rr_m0_ack", {30'h0, m1_ack, m0_ack}, 32'h1);
            check("rr_m0_rdata", m0_rdata, 32'h1234BEEF);
         end
         if (n == 7 || n == 15) begin
            check("rr_m1_ack", {30'h0, m1_ack, m0_ack}, 32'h2);
            check("rr_m1_rdata", m1_rdata, 32'h0000A5A5);
         end
         if (n == 15) begin
            drive(0, 1'b0, 8'h0, 32'h0, 4'h0);
            drive(1, 1'b0, 8'h0, 32'h0, 4'h0);
         end
      end
      check("rr_ack_count", 32'(acks), 32'd4);
      last_rd[0] = 32'h1234BEEF;
      last_rd[1] = 32'h0000A5A5;

      // Memory never answers: timeout after 15 wait cycles, then a normal read.
      stall = 1'b1;
      run_txn(0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b1, 17);
      stall = 1'b0;
      run_txn(0, 8'h20, 32'h0, 4'h0, 32'h0000A5A5, 1'b0, 3);

      // Reset while waiting on memory aborts silently.
      stall = 1'b1;
      drive(0, 1'b1, 8'h30, 32'h0, 4'h0);
      acks = 0;
      for (n = 0; n < 3; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (m0_ack || m1_ack) acks++;
      end
      check("abort_no_early_ack", 32'(acks), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_acks", {28'h0, m1_err, m1_ack, m0_err, m0_ack}, 32'h0);
      check("abort_mem_enable", 32'(mem_enable), 32'd0);
      check("abort_mem_rw", 32'(mem_rw), 32'd0);
      check("abort_mem_addr", 32'(mem_addr), 32'd0);
      check("abort_mem_data_in", mem_data_in, 32'h0);
      check("abort_m0_rdata", m0_rdata, 32'h0);
      check("abort_m1_rdata", m1_rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0; stall = 1'b0;
      last_rd[0] = 32'h0;
      last_rd[1] = 32'h0;
      drive(0, 1'b0, 8'h0, 32'h0, 4'h0);
      run_txn(1, 8'h20, 32'h0, 4'h0, 32'h0000A5A5, 1'b0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
